aftab_seq_opt_adder: RTL
========================

// Module: aftab_seq_opt_adder
// PURPOSE
//  Multi-cycle, parametrised successor to the AFTAB fixed-increment adder. Computes
//  sum = a + zext(b) + cin, CHUNK bits per clock, with a start/done handshake.
//  Terminates early once the carry dies and the remaining b bits are zero; the upper
//  bits of a are then copied straight to sum.
//  Used by the datapath for PC/address increments and small-offset adds in area-lean builds.
// PARAMETERS
//  SIZE    32  operand/result width; SIZE % CHUNK == 0 required (elaboration error otherwise)
//  CHUNK   8   bits processed per cycle, 1..SIZE
//  BWIDTH  2   width of b, 1..SIZE, zero-extended to SIZE
// PORTS
//  clk    in   1       clock, rising edge
//  rst    in   1       synchronous reset, active-low (sampled on clk rise while 0)
//  start  in   1       request; accepted only on an edge where ready=1
//  a      in   SIZE    operand A, captured at accept
//  b      in   BWIDTH  operand B, captured at accept
//  cin    in   1       carry-in, captured at accept
//  ready  out  1       1 only in IDLE
//  busy   out  1       1 in CALC
//  done   out  1       one-cycle pulse; sum/cout valid in this cycle
//  sum    out  SIZE    result; held from DONE until the next accept
//  cout   out  1       carry out of bit SIZE-1; 0 on early exit
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0,
//   chunk index k=0. Reset mid-CALC aborts the operation and discards any partial result.
//  FSM: IDLE -> CALC on start. CALC -> CALC while not finished. CALC -> DONE when finished.
//   DONE -> IDLE unconditionally.
//  Accept edge: latch A=a, B=zext(b), carry c=cin, k=0. sum is not cleared at accept.
//  Each CALC edge processes chunk k (bits k*CHUNK +: CHUNK):
//   {c', s} = A[k] + B[k] + c. Write s into sum[k]; c <= c'; k <= k+1.
//  Finish conditions, evaluated on the same edge:
//   - k == N-1 (N = SIZE/CHUNK): last chunk; cout <= c'.
//   - Early exit: c' == 0 and B bits above chunk k are all zero. Copy A's upper chunks
//     into sum on that edge; cout <= 0.
//  Latency: with L chunks processed (1..N), done is high in the cycle beginning L edges
//   after the accept edge. busy is high for exactly L cycles.
//  start while ready=0 (CALC or DONE) is ignored, not queued. start in the DONE cycle is
//   also ignored; accept becomes possible the following cycle.
//  Operands are sampled only at accept; changes to a, b and cin during CALC have no effect.
//  Wrap-around: all-ones + 1 gives sum=0, cout=1, L=N. Arithmetic is unsigned modulo 2^SIZE.
//  Throughput: at most one operation per L+2 cycles.
// TESTING (SIZE=32, CHUNK=8, BWIDTH=2 unless noted)
//  1. a=0x12345678, b=0, cin=0 -> early exit after 1 chunk; done 1 cycle after accept;
//     sum=0x12345678, cout=0.
//  2. a=0x000000FF, b=2, cin=0 -> L=2; sum=0x00000101, cout=0; busy high 2 cycles.
//  3. a=0xFFFFFFFF, b=1, cin=0 -> L=4; sum=0x00000000, cout=1.
//  4. a=0x0000FFFE, b=3, cin=1 -> L=3; sum=0x00010002, cout=0.
//  5. Reset in 2nd CALC cycle of test 3 -> next edge: ready=1, sum=0, cout=0, no done pulse.
//     New start then completes normally.
//  6. start held high through CALC and DONE -> exactly one done per accept.
//     Gap of one IDLE cycle between done and the next busy.
//  7. Random a/b/cin, also with CHUNK=1/4/32 -> sum/cout match the reference model.
//     L equals the predicted early-exit chunk count.

Source files
------------

// File: rtl/aftab_seq_opt_adder_if.sv
// Request/response bundle for the sequential chunked adder.
// The requester drives start and the operands; the adder returns status and result.
interface aftab_seq_opt_adder_if #(
    parameter int SIZE   = 32,
    parameter int BWIDTH = 2
);
    logic              start;
    logic [SIZE-1:0]   a;
    logic [BWIDTH-1:0] b;
    logic              cin;
    logic              ready;
    logic              busy;
    logic              done;
    logic [SIZE-1:0]   sum;
    logic              cout;

    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout
    );
endinterface

// File: rtl/aftab_seq_opt_adder.sv
// Multi-cycle a + zext(b) + cin, CHUNK bits per clock, with start/done handshake.
// Stops as soon as the carry dies and no b bits remain; upper bits of a are copied.
module aftab_seq_opt_adder #(
    parameter int SIZE   = 32,
    parameter int CHUNK  = 8,
    parameter int BWIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    aftab_seq_opt_adder_if.slave bus
);
    localparam int N  = SIZE / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SIZE-1:0] CMASK = SIZE'({CHUNK{1'b1}});

    if ((CHUNK < 1) || (CHUNK > SIZE) || (SIZE % CHUNK != 0)) begin : g_bad_chunk
        $error("aftab_seq_opt_adder: CHUNK must divide SIZE");
    end
    if ((BWIDTH < 1) || (BWIDTH > SIZE)) begin : g_bad_bwidth
        $error("aftab_seq_opt_adder: BWIDTH must be in 1..SIZE");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic            c_q, c_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SIZE-1:0] sum_q, sum_d;
    logic            cout_q, cout_d;

    // Datapath for the chunk selected by k_q
    logic [31:0]      base;
    logic [SIZE-1:0]  hi_mask;
    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   add;
    logic [SIZE-1:0]  sum_wr;
    logic             last, early;

    always_comb begin
        base    = 32'(k_q) * 32'(CHUNK);
        hi_mask = {SIZE{1'b1}} << (base + 32'(CHUNK));
        a_ch    = CHUNK'(a_q >> base);
        b_ch    = CHUNK'(b_q >> base);
        add     = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_q};
        sum_wr  = (sum_q & ~(CMASK << base)) | (SIZE'(add[CHUNK-1:0]) << base);
        last    = (k_q == KW'(N - 1));
        early   = !add[CHUNK] && ((b_q & hi_mask) == '0);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = SIZE'(bus.b);
                    c_d     = bus.cin;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d = sum_wr;
                c_d   = add[CHUNK];
                k_d   = k_q + KW'(1);
                if (last) begin
                    cout_d  = add[CHUNK];
                    state_d = DONE;
                end else if (early) begin
                    // Nothing left to propagate: the rest of the result is just a
                    sum_d   = (sum_wr & ~hi_mask) | (a_q & hi_mask);
                    cout_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q == CALC);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
endmodule
